net_bus_tx_n: RTL and testbench
===============================

Name: net_bus_tx_n

Overview:
- Parametrised successor to the 3-way NetBus transmit fan-out.
- Registers one NetBus word and delivers it to CHANNELS downstream ports, in one of two modes selected per word:
  - broadcast: every enabled channel must accept the word;
  - anycast: one enabled channel, picked round-robin, receives it.
- Each channel is tracked independently, so a slow port never causes duplicate delivery to a fast one.
- Sits between a NetBus source and the per-link NetBus transmitters.

Parameters:
- DATA_WIDTH, 4, NetBus payload unit; word width W = DATA_WIDTH*9+14.
- CHANNELS, 3, number of output channels (2..16).
- CNT_WIDTH, 32, width of the SENT_CNT counter.

Ports:
- CLK  in  1  single clock for the block; forwarded to all channels.
- RST  in  1  synchronous, active-high reset.
- DATA  in  W  input NetBus word.
- MODE  in  1  0 = broadcast, 1 = anycast; qualified by VALID.
- VALID  in  1  input word valid.
- READY  out  1  block can accept the input word this cycle.
- CH_EN  in  CHANNELS  per-channel enable mask; sampled when a word is loaded.
- WCLK  out  CHANNELS  every bit equals CLK.
- WDATA  out  CHANNELS*W  channel i occupies bits [i*W +: W]; every slice equals the held word.
- WVALID  out  CHANNELS  per-channel valid.
- WREADY  in  CHANNELS  per-channel ready.
- SENT_CNT  out  CNT_WIDTH  count of completed words; wraps.
- DROP_CNT  out  16  count of words loaded with an empty target mask; saturates at 0xFFFF.

Behaviour:
- **State:**
  - hold_valid, hold_data, pending[CHANNELS], rr_ptr (index of the last anycast grant), counters.
- **Reset (RST high at a CLK edge):**
  - hold_valid=0, pending=0, rr_ptr=CHANNELS-1 (so the first anycast pick is channel 0), SENT_CNT=0, DROP_CNT=0.
  - WVALID=0 and READY=0 while RST is high.
  - A reset mid-transfer discards the held word silently; no counter update.
- **Transfer rules:**
  - A channel transfer occurs when WVALID[i]&WREADY[i] at a CLK edge.
  - The input is accepted when VALID&READY at a CLK edge.
- **Per-channel valid:**
  - WVALID[i] = hold_valid & pending[i].
  - Once asserted, WVALID[i] and WDATA hold until that channel transfers (no retraction).
- **Completion:**
  - complete = hold_valid & ((pending & ~(WVALID&WREADY)) == 0).
- **Input ready:**
  - READY = ~RST & (~hold_valid | complete).
  - This is a combinational path from WREADY to READY.
  - Sustains 1 word/cycle when all targeted channels are ready.
- **Latency:**
  - A word accepted at edge T drives WVALID from cycle T+1.
  - The earliest completion is edge T+1.
- **Load (accept edge):**
  - hold_data <= DATA.
  - Broadcast: pending <= CH_EN.
  - Anycast: pending <= onehot(g), where g is the first index with CH_EN[g]=1, searching cyclically from rr_ptr+1; rr_ptr <= g.
  - If the target mask is zero (CH_EN==0): hold_valid stays/becomes 0, DROP_CNT increments (saturating), SENT_CNT is unchanged, and no WVALID is asserted.
  - Otherwise hold_valid <= 1.
- **Transfer edges:**
  - Each transferring channel clears its pending bit.
  - At the completion edge, SENT_CNT increments by 1, even for broadcast to several channels.
  - If a new word is accepted at the same edge, the load overrides the clear; otherwise hold_valid <= 0.
- **Mask timing:**
  - CH_EN changes while a word is held do not affect that word's pending mask.
- **Channel independence:**
  - Each channel transfers at most once per word.
  - Channels may accept in different cycles, in any order.
- **Simultaneous events:**
  - Completion plus a new input in the same cycle gives back-to-back operation with no bubble.
  - A zero-mask word arriving at a completion edge: the old word is counted in SENT_CNT, the new one in DROP_CNT, and hold_valid <= 0.
- **Anycast fairness:**
  - The pointer advances only on an anycast load.
  - Broadcast words do not move it.
  - A disabled channel is skipped.

Decomposition:
- **Package net_bus_pkg:**
  - function net_bus_width(DATA_WIDTH) = DATA_WIDTH*9+14.
  - MODE_BCAST=1'b0, MODE_ANY=1'b1.
- **Sub-module net_bus_rr_pick (combinational):**
  - Parameter N.
  - Inputs mask[N] and ptr[$clog2(N)].
  - Outputs grant_idx and grant_valid: the first set bit of mask strictly after ptr, cyclically.
  - Unit-testable alone.

Test Plan:
- **Reset:** RST=1 for 3 cycles with VALID=1 -> READY=0, WVALID=0; after release READY=1, SENT_CNT=0, DROP_CNT=0.
- **Broadcast, staggered ready:** CHANNELS=3, CH_EN=3'b111, MODE=0, DATA=0x2A5, WREADY 1 on ch0 at T+1, ch2 at T+2, ch1 at T+4 -> each WVALID drops the cycle after its transfer; READY=0 until the T+4 edge; each channel sees exactly one transfer of 0x2A5; SENT_CNT=1.
- **Anycast rotation:** CH_EN=3'b111, all WREADY=1, 4 back-to-back anycast words -> grants ch0, ch1, ch2, ch0; READY stays 1 (1 word/cycle); SENT_CNT=4.
- **Anycast skip:** CH_EN=3'b101 -> grants alternate ch0, ch2, ch0; then CH_EN=3'b000 for one word -> DROP_CNT=1, no WVALID, READY stays 1.
- **Back-pressure and mask isolation:** broadcast with CH_EN=3'b011 held (WREADY=0) while CH_EN changes to 3'b100 -> only ch0/ch1 are valid; ch2 never is; WDATA is stable until completion.
- **Reset mid-transfer:** broadcast with ch0 done and ch1 pending, then RST pulse -> WVALID=0 and SENT_CNT=0 next cycle; a following word is delivered normally.

Source files
------------

// File: rtl/net_bus_pkg.sv
// Shared NetBus definitions: word width helper and transfer mode codes.
package net_bus_pkg;

  localparam logic MODE_BCAST = 1'b0;
  localparam logic MODE_ANY   = 1'b1;

  // A NetBus word carries nine payload units plus 14 framing/control bits.
  function automatic int net_bus_width(input int data_width);
    return data_width * 9 + 14;
  endfunction

endpackage

// File: rtl/net_bus_rr_pick.sv
// Round-robin picker: finds the first set mask bit strictly after ptr,
// wrapping around, so the channel at ptr itself is considered last.
module net_bus_rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant_idx,
  output logic          grant_valid
);

  // Cyclic scan starting one past the last grant.
  always_comb begin
    int j;
    logic [PW-1:0] jv;
    j           = 0;
    jv          = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j  = (int'(ptr) + k) % N;
      jv = PW'(j);
      if (!grant_valid && mask[jv]) begin
        grant_valid = 1'b1;
        grant_idx   = jv;
      end
    end
  end

endmodule

// File: rtl/net_bus_tx_n.sv
// NetBus transmit fan-out: holds one word and delivers it to CHANNELS ports,
// either to every enabled port (broadcast) or to one port picked round-robin
// (anycast). Each port is tracked on its own so no port sees a word twice.
//
// Handshake: every port uses valid/ready. A transfer happens at a CLK edge
// where valid and ready are both high. Valid, once raised, stays high with
// stable data until its transfer; ready may come and go freely. The input
// side follows the same rules with VALID/READY; READY depends combinationally
// on WREADY so a completing word can be replaced in the same cycle.
module net_bus_tx_n
  import net_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int CHANNELS   = 3,
  parameter int CNT_WIDTH  = 32,
  localparam int W         = net_bus_width(DATA_WIDTH),
  localparam int PTR_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [W-1:0]          DATA,
  input  logic                  MODE,
  input  logic                  VALID,
  output logic                  READY,
  input  logic [CHANNELS-1:0]   CH_EN,
  output logic [CHANNELS-1:0]   WCLK,
  output logic [CHANNELS*W-1:0] WDATA,
  output logic [CHANNELS-1:0]   WVALID,
  input  logic [CHANNELS-1:0]   WREADY,
  output logic [CNT_WIDTH-1:0]  SENT_CNT,
  output logic [15:0]           DROP_CNT
);

  logic                hold_valid;
  logic [W-1:0]        hold_data;
  logic [CHANNELS-1:0] pending;
  logic [PTR_W-1:0]    rr_ptr;

  logic [CHANNELS-1:0] xfer;
  logic                complete;
  logic                accept;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_valid;
  logic [CHANNELS-1:0] grant_oh;
  logic [CHANNELS-1:0] target;

  net_bus_rr_pick #(
    .N  (CHANNELS),
    .PW (PTR_W)
  ) u_pick (
    .mask        (CH_EN),
    .ptr         (rr_ptr),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign WCLK     = {CHANNELS{CLK}};
  assign WDATA    = {CHANNELS{hold_data}};
  // Reset silences the ports immediately, even before the held word is dropped.
  assign WVALID   = {CHANNELS{hold_valid & ~RST}} & pending;
  assign xfer     = WVALID & WREADY;
  assign complete = hold_valid & ((pending & ~xfer) == '0);
  assign READY    = ~RST & (~hold_valid | complete);
  assign accept   = VALID & READY;

  // Target mask for a word being loaded this cycle.
  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      grant_oh[i] = grant_valid && (grant_idx == PTR_W'(i));
    end
    target = (MODE == MODE_ANY) ? grant_oh : CH_EN;
  end

  // Hold register, per-channel pending bits, anycast pointer and counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      pending    <= '0;
      rr_ptr     <= PTR_W'(CHANNELS - 1);
      SENT_CNT   <= '0;
      DROP_CNT   <= '0;
    end else begin
      if (complete) begin
        SENT_CNT <= SENT_CNT + 1'b1;
      end
      if (accept) begin
        // A fresh load replaces whatever the transfer clear would have left.
        hold_data  <= DATA;
        pending    <= target;
        hold_valid <= (target != '0);
        if (target == '0 && DROP_CNT != 16'hFFFF) begin
          DROP_CNT <= DROP_CNT + 16'd1;
        end
        if (MODE == MODE_ANY && grant_valid) begin
          rr_ptr <= grant_idx;
        end
      end else begin
        pending <= pending & ~xfer;
        if (complete) begin
          hold_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_net_bus_tx_n.sv
// Bench for net_bus_tx_n: directed scenarios followed by random traffic,
// every cycle compared against a word-level reference model.
module tb_net_bus_tx_n;
  import net_bus_pkg::*;

  localparam int DW = 4;
  localparam int CH = 3;
  localparam int CW = 32;
  localparam int W  = net_bus_width(DW);

  // ---------------- clock / reset / DUT ----------------
  logic              CLK;
  logic              RST;
  logic [W-1:0]      DATA;
  logic              MODE;
  logic              VALID;
  logic              READY;
  logic [CH-1:0]     CH_EN;
  logic [CH-1:0]     WCLK;
  logic [CH*W-1:0]   WDATA;
  logic [CH-1:0]     WVALID;
  logic [CH-1:0]     WREADY;
  logic [CW-1:0]     SENT_CNT;
  logic [15:0]       DROP_CNT;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  net_bus_tx_n #(
    .DATA_WIDTH (DW),
    .CHANNELS   (CH),
    .CNT_WIDTH  (CW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DATA     (DATA),
    .MODE     (MODE),
    .VALID    (VALID),
    .READY    (READY),
    .CH_EN    (CH_EN),
    .WCLK     (WCLK),
    .WDATA    (WDATA),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .SENT_CNT (SENT_CNT),
    .DROP_CNT (DROP_CNT)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The held word, the set of channels still owed it, the last anycast
  // grant, and plain integer counters.
  bit            m_hold;
  logic [W-1:0]  m_data;
  bit            m_owed [CH];
  int            m_last;
  longint        m_sent;
  int            m_drop;

  // Scoreboard: words each channel is still expected to receive, in order.
  logic [W-1:0] exp_q [CH][$];

  task automatic model_reset();
    m_hold = 0;
    m_data = '0;
    for (int i = 0; i < CH; i++) begin
      m_owed[i] = 0;
      exp_q[i].delete();
    end
    m_last = CH - 1;
    m_sent = 0;
    m_drop = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic m, input logic [W-1:0] d,
                       input logic [CH-1:0] en, input logic [CH-1:0] wr);
    VALID  = v;
    MODE   = m;
    DATA   = d;
    CH_EN  = en;
    WREADY = wr;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // One clock cycle: compare outputs on the falling edge, then advance the
  // model and scoreboard on the rising edge, then release to the driver.
  task automatic cycle();
    bit            done;
    bit            rdy;
    bit            acc;
    int            pick;
    logic [CH-1:0] exp_wv;
    logic [CH-1:0] obs_xfer;
    logic [CH*W-1:0] obs_wd;
    logic [CH-1:0] en;
    logic [W-1:0]  popped;

    @(negedge CLK);
    done = m_hold;
    for (int i = 0; i < CH; i++) if (m_owed[i] && !WREADY[i]) done = 0;
    rdy = !RST && (!m_hold || done);
    exp_wv = '0;
    for (int i = 0; i < CH; i++) if (!RST && m_hold && m_owed[i]) exp_wv[i] = 1'b1;

    chk("ready",  64'(READY),    64'(rdy));
    chk("wvalid", 64'(WVALID),   64'(exp_wv));
    chk("sent",   64'(SENT_CNT), 64'(m_sent[31:0]));
    chk("drop",   64'(DROP_CNT), 64'(m_drop));
    chk("wclk",   64'(WCLK),     64'(0));
    for (int i = 0; i < CH; i++)
      if (exp_wv[i]) chk("wdata", 64'(WDATA[i*W +: W]), 64'(m_data));
    obs_xfer = WVALID & WREADY;
    obs_wd   = WDATA;

    @(posedge CLK);
    if (RST) begin
      model_reset();
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (obs_xfer[i]) begin
          if (exp_q[i].size() == 0) begin
            chk("extra_xfer", 64'(i), 64'(CH));
          end else begin
            popped = exp_q[i].pop_front();
            chk("xfer_data", 64'(obs_wd[i*W +: W]), 64'(popped));
          end
        end
      end
      if (done) m_sent++;
      acc = VALID && rdy;
      if (acc) begin
        en = '0;
        if (MODE == MODE_ANY) begin
          pick = -1;
          for (int k = 1; k <= CH; k++)
            if (pick < 0 && CH_EN[(m_last + k) % CH]) pick = (m_last + k) % CH;
          if (pick >= 0) begin
            en[pick] = 1'b1;
            m_last   = pick;
          end
        end else begin
          en = CH_EN;
        end
        if (en == '0) begin
          if (m_drop < 65535) m_drop++;
          m_hold = 0;
          for (int i = 0; i < CH; i++) m_owed[i] = 0;
        end else begin
          m_hold = 1;
          m_data = DATA;
          for (int i = 0; i < CH; i++) begin
            m_owed[i] = en[i];
            if (en[i]) exp_q[i].push_back(DATA);
          end
        end
      end else begin
        for (int i = 0; i < CH; i++) if (WREADY[i]) m_owed[i] = 0;
        if (done) m_hold = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(1'b0, MODE_BCAST, '0, '0, '0);
    cycle();
    RST = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    RST = 1'b1;
    drive(1'b1, MODE_BCAST, rand_word(), 3'b111, 3'b111);

    // Reset held with VALID high: nothing may be accepted or driven.
    for (int c = 0; c < 3; c++) cycle();
    RST = 1'b0;
    drive(1'b0, MODE_BCAST, '0, 3'b111, '0);
    cycle();
    chk("rst_ready", 64'(READY),    64'(1));
    chk("rst_sent",  64'(SENT_CNT), 64'(0));
    chk("rst_drop",  64'(DROP_CNT), 64'(0));

    // Broadcast with staggered channel readiness.
    drive(1'b1, MODE_BCAST, W'(50'h2A5), 3'b111, 3'b000); cycle();
    drive(1'b0, MODE_BCAST, '0, 3'b111, 3'b001); cycle();
    drive(1'b0, MODE_BCAST, '0, 3'b111, 3'b100); cycle();
    drive(1'b0, MODE_BCAST, '0, 3'b111, 3'b000); cycle();
    drive(1'b0, MODE_BCAST, '0, 3'b111, 3'b010); cycle();
    drive(1'b0, MODE_BCAST, '0, 3'b111, 3'b000); cycle();
    chk("bc_sent", 64'(SENT_CNT), 64'(1));

    // Anycast rotation at full rate.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, MODE_ANY, rand_word(), 3'b111, 3'b111);
      cycle();
    end
    drive(1'b0, MODE_ANY, '0, 3'b111, 3'b111); cycle();
    chk("any_sent", 64'(SENT_CNT), 64'(4));

    // Anycast skipping a disabled channel, then an empty-mask word.
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, MODE_ANY, rand_word(), 3'b101, 3'b111);
      cycle();
    end
    drive(1'b1, MODE_ANY, rand_word(), 3'b000, 3'b111); cycle();
    drive(1'b0, MODE_ANY, '0, 3'b000, 3'b111); cycle();
    chk("skip_sent", 64'(SENT_CNT), 64'(7));
    chk("skip_drop", 64'(DROP_CNT), 64'(1));

    // Back-pressure while the enable mask moves underneath the held word.
    drive(1'b1, MODE_BCAST, rand_word(), 3'b011, 3'b000); cycle();
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, MODE_BCAST, '0, 3'b100, 3'b000);
      cycle();
    end
    drive(1'b0, MODE_BCAST, '0, 3'b100, 3'b111); cycle();
    drive(1'b0, MODE_BCAST, '0, 3'b100, 3'b000); cycle();
    chk("iso_sent", 64'(SENT_CNT), 64'(8));

    // Reset mid-transfer, then a normal delivery.
    do_reset();
    drive(1'b1, MODE_BCAST, rand_word(), 3'b011, 3'b000); cycle();
    drive(1'b0, MODE_BCAST, '0, 3'b011, 3'b001); cycle();
    drive(1'b0, MODE_BCAST, '0, 3'b011, 3'b000); cycle();
    RST = 1'b1; cycle();
    RST = 1'b0; cycle();
    chk("mid_rst_sent", 64'(SENT_CNT), 64'(0));
    chk("mid_rst_wv",   64'(WVALID),   64'(0));
    drive(1'b1, MODE_BCAST, rand_word(), 3'b111, 3'b111); cycle();
    drive(1'b0, MODE_BCAST, '0, 3'b111, 3'b111); cycle();
    chk("post_rst_sent", 64'(SENT_CNT), 64'(1));

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), rand_word(),
            CH'($urandom_range(0, 7)), CH'($urandom_range(0, 7)));
      cycle();
    end

    // Drain and confirm every owed delivery happened.
    RST = 1'b0;
    drive(1'b0, MODE_BCAST, '0, 3'b111, 3'b111);
    for (int c = 0; c < 3; c++) cycle();
    for (int i = 0; i < CH; i++) chk("q_empty", 64'(exp_q[i].size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
